// File: rtl/fifo_access_pkg.sv
// Shared types and helpers for the FIFO access controller: arbiter states,
// output-buffer depth, grant-id width and the round-robin pick function.
package fifo_access_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int OB_DEPTH = 2;
  localparam int GID_W    = 3;
  localparam int MAX_REQ  = 8;

  // First set bit of vld at or after ptr, wrapping at n; returns ptr if none set.
  function automatic logic [GID_W-1:0] rr_first(input logic [MAX_REQ-1:0] vld,
                                                input logic [GID_W-1:0]   ptr,
                                                input int                 n);
    logic [GID_W-1:0] pick;
    logic             found;
    int               j;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (!found && (k < n) && vld[j[2:0]]) begin
        pick  = j[GID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Read-side prefetcher: rd_op in cycle N shows on out_data in N+2; at most two
// words committed (buffered + in flight), so out_ready low simply stops reads.
module fifo_prefetch_buf
  import fifo_access_pkg::*;
#(
  parameter int DAT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DAT_WIDTH-1:0] fifo_rd_data,
  output logic                 fifo_rd_op,
  output logic                 out_valid,
  output logic [DAT_WIDTH-1:0] out_data,
  input  logic                 out_ready
);

  logic [1:0]           ob_cnt_q, ob_cnt_d;
  logic                 rd_pend_q;
  logic [DAT_WIDTH-1:0] ob_q [OB_DEPTH];
  logic [DAT_WIDTH-1:0] ob_d [OB_DEPTH];
  logic                 pop;
  logic [2:0]           committed;

  assign out_valid = (ob_cnt_q != 2'd0);
  assign out_data  = ob_q[0];
  assign pop       = out_valid & out_ready;

  // Words that will occupy the buffer next cycle if no new read is issued.
  assign committed  = {1'b0, ob_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign fifo_rd_op = ~reset & ~fifo_empty & (committed < 3'(OB_DEPTH));

  always_comb begin
    ob_d     = ob_q;
    ob_cnt_d = ob_cnt_q;
    case ({rd_pend_q, pop})
      2'b10: begin
        if (ob_cnt_q == 2'd0) ob_d[0] = fifo_rd_data;
        else                  ob_d[1] = fifo_rd_data;
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      2'b01: begin
        ob_d[0]  = ob_q[1];
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob_d[0] = fifo_rd_data;
        end else begin
          ob_d[0] = ob_q[1];
          ob_d[1] = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ob_cnt_q  <= 2'd0;
      rd_pend_q <= 1'b0;
      for (int i = 0; i < OB_DEPTH; i++) ob_q[i] <= '0;
    end else begin
      ob_cnt_q  <= ob_cnt_d;
      rd_pend_q <= fifo_rd_op;
      ob_q      <= ob_d;
    end
  end

endmodule

// File: rtl/fifo_a64d32_access_ctrl.sv
// Shares one 64x32 FIFO among NUM_REQ writers (registered round-robin grant, burst hold)
// and streams it out via a 2-deep prefetch; fifo_full gates req_ready, out_ready gates reads.
module fifo_a64d32_access_ctrl
  import fifo_access_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DAT_WIDTH = 32,
  parameter int PTR_WIDTH = 6,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [GID_W-1:0]             grant_id,
  output logic                         grant_act,
  output logic                         fifo_wr_op,
  output logic [DAT_WIDTH-1:0]         fifo_wr_data,
  output logic [DAT_WIDTH-1:0]         fifo_wr_mask,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  input  logic [PTR_WIDTH:0]           fifo_entry_used,
  output logic                         fifo_rd_op,
  input  logic [DAT_WIDTH-1:0]         fifo_rd_data,
  input  logic                         fifo_wr_full_err,
  input  logic                         fifo_rd_empty_err,
  output logic                         out_valid,
  output logic [DAT_WIDTH-1:0]         out_data,
  input  logic                         out_ready,
  output logic [1:0]                   err_sticky
);

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  arb_state_e           state_q;
  logic [GID_W-1:0]     owner_q, rr_ptr_q;
  logic [3:0]           beat_cnt_q;
  logic                 own_vld;
  logic [DAT_WIDTH-1:0] own_dat;
  logic                 beat;
  logic [GID_W-1:0]     pick;
  logic [GID_W-1:0]     next_ptr;
  logic [1:0]           err_q;
  logic [PTR_WIDTH:0]   entry_used_q;
  logic                 status_unused;

  always_comb begin
    own_vld = 1'b0;
    own_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == GID_W'(i)) begin
        own_vld = req_valid[i];
        own_dat = req_data[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign grant_act = (state_q == GRANT);
  assign grant_id  = owner_q;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = grant_act && (owner_q == GID_W'(i)) && !fifo_full;
  end

  // A full FIFO can never see a write: the beat itself requires !fifo_full.
  assign beat         = grant_act & own_vld & ~fifo_full;
  assign fifo_wr_op   = beat;
  assign fifo_wr_data = beat ? own_dat : '0;
  assign fifo_wr_mask = '1;

  assign pick     = rr_first(MAX_REQ'(req_valid), rr_ptr_q, NUM_REQ);
  assign next_ptr = (owner_q == GID_W'(NUM_REQ - 1)) ? '0 : owner_q + GID_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            owner_q    <= pick;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (!own_vld || (beat && (beat_cnt_q == LAST_BEAT))) begin
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q        <= 2'b00;
      entry_used_q <= '0;
    end else begin
      err_q        <= err_q | {fifo_rd_empty_err, fifo_wr_full_err};
      entry_used_q <= fifo_entry_used;
    end
  end

  assign err_sticky = err_q;
  // Occupancy is kept for status visibility only; nothing consumes it.
  assign status_unused = ^entry_used_q;

  fifo_prefetch_buf #(
    .DAT_WIDTH(DAT_WIDTH)
  ) u_pf (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_op  (fifo_rd_op),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

endmodule

// File: tb/tb_fifo_a64d32_access_ctrl.sv
// Bench for fifo_a64d32_access_ctrl: behavioural 64x32 FIFO, table-driven vectors
// plus a write-to-output scoreboard queue and hand-written corner sequences.
module tb_fifo_a64d32_access_ctrl;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int PW = 6;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [2:0]       grant_id;
  logic             grant_act;
  logic             fifo_wr_op;
  logic [DW-1:0]    fifo_wr_data;
  logic [DW-1:0]    fifo_wr_mask;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PW:0]      fifo_entry_used;
  logic             fifo_rd_op;
  logic [DW-1:0]    fifo_rd_data;
  logic             fifo_wr_full_err;
  logic             fifo_rd_empty_err;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  logic [1:0]       err_sticky;

  fifo_a64d32_access_ctrl #(
    .NUM_REQ(NR), .DAT_WIDTH(DW), .PTR_WIDTH(PW), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .grant_act(grant_act),
    .fifo_wr_op(fifo_wr_op), .fifo_wr_data(fifo_wr_data), .fifo_wr_mask(fifo_wr_mask),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_entry_used(fifo_entry_used),
    .fifo_rd_op(fifo_rd_op), .fifo_rd_data(fifo_rd_data),
    .fifo_wr_full_err(fifo_wr_full_err), .fifo_rd_empty_err(fifo_rd_empty_err),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO envelope: 64 entries, registered 1-cycle read.
  logic [DW-1:0] mem [64];
  int            fcnt, wp, rp;
  logic [DW-1:0] rdat;
  logic          werr, rerr;
  logic [1:0]    err_inj;

  assign fifo_full         = (fcnt == 64);
  assign fifo_empty        = (fcnt == 0);
  assign fifo_entry_used   = 7'(fcnt);
  assign fifo_rd_data      = rdat;
  assign fifo_wr_full_err  = werr | err_inj[0];
  assign fifo_rd_empty_err = rerr | err_inj[1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt <= 0; wp <= 0; rp <= 0; rdat <= '0; werr <= 1'b0; rerr <= 1'b0;
    end else begin
      werr <= fifo_wr_op && fifo_full;
      rerr <= fifo_rd_op && fifo_empty;
      if (fifo_wr_op && !fifo_full) begin mem[wp] <= fifo_wr_data; wp <= (wp + 1) % 64; end
      if (fifo_rd_op && !fifo_empty) begin rdat <= mem[rp]; rp <= (rp + 1) % 64; end
      fcnt <= fcnt + ((fifo_wr_op && !fifo_full) ? 1 : 0) - ((fifo_rd_op && !fifo_empty) ? 1 : 0);
    end
  end

  typedef struct {
    logic [3:0]  vld;
    logic        ordy;
    logic [10:0] ctl;   // {req_ready, grant_act, grant_id, wr_op, rd_op, out_valid}
    logic [31:0] wd;
    logic [31:0] od;
  } vec_t;

  vec_t          tbl [9];
  int            checks, errors;
  logic [31:0]   exp_q [$];
  int            glog [$];
  int            gbeats [$];
  int            data_cnt [NR];
  int            pushed, popped, wr_cnt, rdop_cnt, outv_cnt;
  int            viol_wr, viol_rd, viol_ob;
  logic          prev_ga;
  int            exp_order [5] = '{0, 1, 2, 3, 0};

  function automatic logic [31:0] tag(input int i, input int n);
    return 32'(32'hA0 + i * 256 + n);
  endfunction

  function automatic logic [10:0] mk_ctl(input logic [3:0] rdy, input logic ga, input logic [2:0] gid,
                                         input logic wr, input logic rd, input logic ov);
    return {rdy, ga, gid, wr, rd, ov};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk); #2;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        chk("wr_strobe", 64'(fifo_wr_op), 64'd1);
        chk("wr_data", 64'(fifo_wr_data), 64'(tag(i, data_cnt[i])));
        exp_q.push_back(tag(i, data_cnt[i]));
        pushed++; wr_cnt++; data_cnt[i]++;
      end
    end
    if (fifo_wr_op && fifo_full) viol_wr++;
    if (fifo_rd_op && fifo_empty) viol_rd++;
    if (fifo_rd_op) rdop_cnt++;
    if (out_valid) outv_cnt++;
    if (dut.u_pf.ob_cnt_q > 2'd2) viol_ob++;
    if (grant_act && !prev_ga) begin glog.push_back(int'(grant_id)); gbeats.push_back(0); end
    if (fifo_wr_op && gbeats.size() > 0) gbeats[gbeats.size()-1]++;
    prev_ga = grant_act;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got 0x%0h, want no output", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        popped++;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = tag(i, data_cnt[i]);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; out_ready = 1'b0; err_inj = 2'b00;
    exp_q.delete(); prev_ga = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    tbl[0] = '{4'h0, 1'b1, mk_ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), 32'h0,  32'h0};
    tbl[1] = '{4'h1, 1'b1, mk_ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), 32'h0,  32'h0};
    tbl[2] = '{4'h1, 1'b1, mk_ctl(4'b0001, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0), 32'hA0, 32'h0};
    tbl[3] = '{4'h1, 1'b1, mk_ctl(4'b0001, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0), 32'hA1, 32'h0};
    tbl[4] = '{4'h1, 1'b1, mk_ctl(4'b0001, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0), 32'hA2, 32'h0};
    tbl[5] = '{4'h0, 1'b1, mk_ctl(4'b0001, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1), 32'h0,  32'hA0};
    tbl[6] = '{4'h0, 1'b1, mk_ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1), 32'h0,  32'hA1};
    tbl[7] = '{4'h0, 1'b1, mk_ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1), 32'h0,  32'hA2};
    tbl[8] = '{4'h0, 1'b1, mk_ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0), 32'h0,  32'h0};

    checks = 0; errors = 0; pushed = 0; popped = 0; wr_cnt = 0; rdop_cnt = 0; outv_cnt = 0;
    viol_wr = 0; viol_rd = 0; viol_ob = 0;
    for (int i = 0; i < NR; i++) data_cnt[i] = 0;
    req_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = tag(i, 0);
    do_reset();

    chk("rst_wr_mask", 64'(fifo_wr_mask), 64'hFFFF_FFFF);
    chk("rst_err", 64'(err_sticky), 64'd0);

    // Single requester, three beats, full read latency visible.
    for (int r = 0; r < 9; r++) begin
      req_valid = tbl[r].vld;
      out_ready = tbl[r].ordy;
      sample();
      chk($sformatf("vec%0d_ctl", r),
          64'({req_ready, grant_act, grant_id, fifo_wr_op, fifo_rd_op, out_valid}), 64'(tbl[r].ctl));
      chk($sformatf("vec%0d_dat", r),
          64'({fifo_wr_op ? fifo_wr_data : 32'h0, out_valid ? out_data : 32'h0}),
          64'({tbl[r].wd, tbl[r].od}));
      advance();
    end

    // All requesters busy: round-robin order and fixed burst length.
    do_reset();
    glog.delete(); gbeats.delete();
    out_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 200 && glog.size() < 6; c++) step();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      if (k < glog.size()) begin
        chk($sformatf("grant%0d_id", k), 64'(glog[k]), 64'(exp_order[k]));
        chk($sformatf("grant%0d_beats", k), 64'(gbeats[k]), 64'd4);
      end else begin
        checks++; errors++;
        $display("FAIL grant%0d_missing: got %0d grants, want 5", k, glog.size());
      end
    end
    drain(200);

    // Backpressure until full: only two reads in flight, then full drain.
    do_reset();
    rdop_cnt = 0; wr_cnt = 0; popped = 0;
    out_ready = 1'b0; req_valid = 4'h1;
    for (int c = 0; c < 300 && wr_cnt < 66; c++) step();
    for (int c = 0; c < 6; c++) step();
    chk("full_writes", 64'(wr_cnt), 64'd66);
    chk("full_flag", 64'(fifo_full), 64'd1);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    chk("full_rd_ops", 64'(rdop_cnt), 64'd2);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    req_valid = '0; out_ready = 1'b1;
    drain(300);
    chk("full_drained", 64'(popped), 64'd66);
    chk("full_err", 64'(err_sticky), 64'd0);

    // Empty FIFO with a willing sink.
    rdop_cnt = 0; outv_cnt = 0;
    for (int c = 0; c < 10; c++) step();
    chk("empty_rd_ops", 64'(rdop_cnt), 64'd0);
    chk("empty_out_valid", 64'(outv_cnt), 64'd0);
    chk("empty_err", 64'(err_sticky), 64'd0);

    // Streaming with out_ready toggling every cycle.
    pushed = 0; popped = 0;
    for (int c = 0; c < 60; c++) begin
      out_ready = (c % 2 == 0); req_valid = 4'b0110;
      step();
    end
    req_valid = '0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      out_ready = (c % 2 == 0);
      step();
    end
    chk("toggle_left", 64'(exp_q.size()), 64'd0);
    chk("toggle_count", 64'(popped), 64'(pushed));
    chk("ob_cnt_bound", 64'(viol_ob), 64'd0);

    // Reset with a read in flight and a buffered word.
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) step();
    req_valid = '0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #2;
      if (dut.u_pf.rd_pend_q && dut.u_pf.ob_cnt_q == 2'd1) begin found = 1'b1; break; end
    end
    chk("rst_setup", 64'(found), 64'd1);
    reset = 1'b1; exp_q.delete(); prev_ga = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_grant_act", 64'(grant_act), 64'd0);
    chk("rst_strobes", 64'({fifo_wr_op, fifo_rd_op, req_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sample();
    chk("rst_no_stale", 64'(out_valid), 64'd0);
    advance();
    chk("rst_rr_grant", 64'({grant_act, grant_id}), 64'({1'b1, 3'd0}));
    req_valid = '0; out_ready = 1'b1;
    drain(50);

    // Sticky error flags.
    do_reset();
    err_inj = 2'b01; step(); err_inj = 2'b00; step();
    chk("err_wr", 64'(err_sticky), 64'd1);
    err_inj = 2'b10; step(); err_inj = 2'b00; step();
    chk("err_both", 64'(err_sticky), 64'd3);
    do_reset();
    chk("err_cleared", 64'(err_sticky), 64'd0);

    chk("wr_while_full", 64'(viol_wr), 64'd0);
    chk("rd_while_empty", 64'(viol_rd), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
